// File: rtl/bram_stream_pkg.sv
// Shared types and sizing helpers for the BRAM-to-stream reader.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned TAG_WIDTH = 1;

  // Two extra slots beyond the read latency keep full throughput under the credit rule.
  function automatic int unsigned fifo_depth(input int unsigned read_latency);
    return read_latency + 2;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with registered storage output and async active-low clear.
module stream_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             valid_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = rd_en_i && (count_q != '0);

  // Writers never push into a full FIFO: the caller reserves space ahead of time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CW'(wr_en_i) - CW'(do_pop);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != '0);

endmodule

// File: rtl/bram_stream_reader.sv
// Replays a window of a block RAM as framed AXI4-Stream packets, one-shot or looping.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic                  cfg_loop,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned FIFO_DEPTH = fifo_depth(READ_LATENCY);
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FW         = DATA_WIDTH + TAG_WIDTH;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     idx_q, idx_d;
  logic                    loop_q, loop_d;
  logic                    stop_pend_q, stop_pend_d;
  logic [CW-1:0]           credit_q, credit_d;
  logic [READ_LATENCY-1:0] pipe_v_q, pipe_tag_q;

  logic                    issue, last_word, xfer;
  logic [FW-1:0]           fifo_rdata;
  logic                    fifo_valid;

  // credit_q counts reads in flight plus words held in the FIFO, so every read has a slot.
  assign issue     = (state_q == ST_RUN) && (credit_q < CW'(FIFO_DEPTH));
  assign last_word = ((idx_q + 1'b1) == len_q);
  assign xfer      = fifo_valid & m_axis_tready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    loop_d      = loop_q;
    stop_pend_d = stop_pend_q;
    credit_d    = credit_q + CW'(issue) - CW'(xfer);
    case (state_q)
      ST_IDLE: begin
        if (start && (cfg_len != '0)) begin
          state_d     = ST_RUN;
          base_d      = cfg_base;
          len_d       = cfg_len;
          loop_d      = cfg_loop;
          addr_d      = cfg_base;
          idx_d       = '0;
          stop_pend_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (issue) begin
          if (last_word) begin
            idx_d  = '0;
            addr_d = base_q;
            if (!loop_q || stop_pend_d) state_d = ST_DRAIN;
          end else begin
            idx_d  = idx_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (credit_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      credit_q    <= '0;
      pipe_v_q    <= '0;
      pipe_tag_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      base_q        <= base_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      loop_q        <= loop_d;
      stop_pend_q   <= stop_pend_d;
      credit_q      <= credit_d;
      pipe_v_q[0]   <= issue;
      pipe_tag_q[0] <= last_word;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (pipe_v_q[READ_LATENCY-1]),
    .wr_data_i ({pipe_tag_q[READ_LATENCY-1], bram_dout}),
    .rd_en_i   (m_axis_tready),
    .rd_data_o (fifo_rdata),
    .valid_o   (fifo_valid)
  );

  assign bram_en       = issue;
  assign bram_addr     = addr_q;
  assign m_axis_tdata  = fifo_rdata[DATA_WIDTH-1:0];
  assign m_axis_tlast  = fifo_rdata[DATA_WIDTH];
  assign m_axis_tvalid = fifo_valid;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = fifo_valid & m_axis_tready & fifo_rdata[DATA_WIDTH];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench: three readers (read latency 1, 2, 3) share stimulus, each with its own BRAM model.
module tb_bram_stream_reader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, stop, cfg_loop, tready;
  logic [AW-1:0] cfg_base;
  logic [AW:0]   cfg_len;

  logic [NI-1:0] en_w, tvalid_w, tlast_w, busy_w, fdone_w;
  logic [AW-1:0] addr_w  [NI];
  logic [DW-1:0] dout_w  [NI];
  logic [DW-1:0] tdata_w [NI];

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW:0] exp_q [NI][$];
  int reads [NI];
  int xfers [NI];
  int frames[NI];
  int snap_r[NI], snap_x[NI], snap_f[NI];
  int first_t[NI], last_t[NI];
  logic [NI-1:0] prev_stall, expect_idle;
  logic [DW:0]   prev_word [NI];

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {a, 3'b101, 8'hA5, 11'h000, a};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [DW-1:0] stage_q [g+1];
    always @(posedge clk) begin
      stage_q[0] <= en_w[g] ? word_of(addr_w[g]) : 32'hDEAD_DEAD;
      for (int i = 1; i <= g; i++) stage_q[i] <= stage_q[i-1];
    end
    assign dout_w[g] = stage_q[g];

    bram_stream_reader #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .READ_LATENCY (g + 1)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .cfg_base      (cfg_base),
      .cfg_len       (cfg_len),
      .cfg_loop      (cfg_loop),
      .bram_en       (en_w[g]),
      .bram_addr     (addr_w[g]),
      .bram_dout     (dout_w[g]),
      .m_axis_tdata  (tdata_w[g]),
      .m_axis_tvalid (tvalid_w[g]),
      .m_axis_tready (tready),
      .m_axis_tlast  (tlast_w[g]),
      .busy          (busy_w[g]),
      .frame_done    (fdone_w[g])
    );
  end

  task automatic check(input string tag, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [rl=%0d] @%0t: got %0h, want %0h", tag, k + 1, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int k);
    return 64'({en_w[k], addr_w[k], tvalid_w[k], tlast_w[k], tdata_w[k], busy_w[k], fdone_w[k]});
  endfunction

  function automatic bit queues_empty();
    for (int k = 0; k < NI; k++) if (exp_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frames(input logic [AW-1:0] base, input int len, input int nfr);
    logic [AW-1:0] a;
    logic [DW:0]   e;
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < len; i++) begin
        a = base + AW'(i);
        e = {(i == len - 1), word_of(a)};
        for (int k = 0; k < NI; k++) exp_q[k].push_back(e);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic snapshot();
    for (int k = 0; k < NI; k++) begin
      snap_r[k] = reads[k];
      snap_x[k] = xfers[k];
      snap_f[k] = frames[k];
    end
  endtask

  task automatic run_watch(input int limit, input bit rnd, input int stop_at);
    bit done;
    done = 1'b0;
    for (int k = 0; k < NI; k++) begin
      first_t[k] = -1;
      last_t[k]  = -1;
    end
    for (int j = 1; j <= limit; j++) begin
      tick();
      stop   = (j == stop_at);
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (tvalid_w[k] && first_t[k] < 0) first_t[k] = j;
        if (tvalid_w[k] && tready) last_t[k] = j;
      end
      if (busy_w == '0 && queues_empty()) begin
        done = 1'b1;
        break;
      end
    end
    stop   = 1'b0;
    tready = 1'b1;
    check("run_completes", 0, 64'(done), 64'(1));
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input int len, input bit loop_en,
                           input int nfr, input bit rnd, input int stop_at, input bit timed);
    cfg_base = base;
    cfg_len  = (AW+1)'(len);
    cfg_loop = loop_en;
    tready   = 1'b1;
    snapshot();
    push_frames(base, len, nfr);
    pulse_start();
    for (int k = 0; k < NI; k++) begin
      check("start_busy", k, 64'(busy_w[k]), 64'(1));
      check("start_en",   k, 64'(en_w[k]),   64'(1));
      check("start_addr", k, 64'(addr_w[k]), 64'(base));
    end
    run_watch(600, rnd, stop_at);
    for (int k = 0; k < NI; k++) begin
      check("xfer_count",  k, 64'(xfers[k]  - snap_x[k]), 64'(nfr * len));
      check("frame_count", k, 64'(frames[k] - snap_f[k]), 64'(nfr));
      check("read_count",  k, 64'(reads[k]  - snap_r[k]), 64'(nfr * len));
      check("busy_end",    k, 64'(busy_w[k]), 64'(0));
      if (timed) begin
        check("first_valid", k, 64'(first_t[k]), 64'(k + 2));
        check("burst_span",  k, 64'(last_t[k] - first_t[k] + 1), 64'(nfr * len));
      end
    end
  endtask

  initial begin
    logic [DW:0] e;
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_loop = 1'b0; tready = 1'b1;
    cfg_base = '0; cfg_len = '0;
    prev_stall = '0; expect_idle = '0;
    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
          if (!rst) begin
            prev_stall[k]  = 1'b0;
            expect_idle[k] = 1'b0;
          end else begin
            if (expect_idle[k]) begin
              check("idle_after_last", k, 64'(busy_w[k]), 64'(0));
              expect_idle[k] = 1'b0;
            end
            if (prev_stall[k])
              check("stall_hold", k, 64'({tvalid_w[k], tlast_w[k], tdata_w[k]}), 64'({1'b1, prev_word[k]}));
            if (en_w[k]) reads[k]++;
            if (tvalid_w[k] && tready) begin
              xfers[k]++;
              if (fdone_w[k]) frames[k]++;
              if (exp_q[k].size() == 0) begin
                check("unexpected_xfer", k, 64'(exp_q[k].size()), 64'(1));
              end else begin
                e = exp_q[k].pop_front();
                check("word", k, 64'({tlast_w[k], tdata_w[k]}), 64'(e));
                check("frame_done", k, 64'(fdone_w[k]), 64'(e[DW]));
                if (exp_q[k].size() == 0) expect_idle[k] = 1'b1;
              end
            end else begin
              check("frame_done_idle", k, 64'(fdone_w[k]), 64'(0));
            end
            prev_stall[k] = tvalid_w[k] && !tready;
            prev_word[k]  = {tlast_w[k], tdata_w[k]};
          end
        end
      end
      begin
        repeat (3) tick();
        for (int k = 0; k < NI; k++) check("reset_outputs", k, outs(k), 64'(0));
        rst = 1'b1;
        tick();

        // one-shot, whole BRAM
        run_frame(5'd0, 32, 1'b0, 1, 1'b0, -1, 1'b1);
        // window wrapping past the top address
        run_frame(5'd30, 4, 1'b0, 1, 1'b0, -1, 1'b1);
        // loop with stop during the second frame's reads
        run_frame(5'd4, 3, 1'b1, 2, 1'b0, 4, 1'b1);
        // random backpressure
        run_frame(5'd7, 32, 1'b0, 1, 1'b1, -1, 1'b0);
        run_frame(5'd19, 17, 1'b1, 1, 1'b1, 9, 1'b0);

        // zero-length start is ignored
        cfg_base = 5'd3; cfg_len = '0; cfg_loop = 1'b0;
        snapshot();
        pulse_start();
        repeat (8) tick();
        for (int k = 0; k < NI; k++) begin
          check("len0_busy",  k, 64'(busy_w[k]), 64'(0));
          check("len0_reads", k, 64'(reads[k] - snap_r[k]), 64'(0));
        end

        // start while busy, with cfg changed mid-run
        cfg_base = 5'd10; cfg_len = 6'd5; cfg_loop = 1'b0;
        snapshot();
        push_frames(5'd10, 5, 1);
        pulse_start();
        tick();
        cfg_base = 5'd20; cfg_len = 6'd8; cfg_loop = 1'b1;
        pulse_start();
        run_watch(200, 1'b0, -1);
        for (int k = 0; k < NI; k++) begin
          check("busy_start_frames", k, 64'(frames[k] - snap_f[k]), 64'(1));
          check("busy_start_xfers",  k, 64'(xfers[k]  - snap_x[k]), 64'(5));
        end

        // asynchronous reset mid-frame
        cfg_base = 5'd12; cfg_len = 6'd8; cfg_loop = 1'b0;
        push_frames(5'd12, 8, 1);
        pulse_start();
        repeat (5) tick();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
          check("async_reset_outputs", k, outs(k), 64'(0));
          exp_q[k].delete();
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_frame(5'd12, 8, 1'b0, 1, 1'b0, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Parametrised BRAM-to-AXI4-Stream reader. It replays a configurable window of a block RAM as framed stream packets, in one-shot or continuous-loop mode. It honours downstream backpressure (`m_axis_tready`) and a configurable BRAM read latency, and it sits between a sample/symbol BRAM and the modulator datapath. It adds start/stop control, a runtime base address and length, and loss-free stalling.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: BRAM address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32: BRAM and stream data width.
- `READ_LATENCY`, 2: cycles from `bram_en`/`bram_addr` to valid `bram_dout`; legal range 1..3.

Ports:
- `clk`  in  1: sole clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle pulse; begins a run when idle.
- `stop`  in  1: one-cycle pulse; ends the run at the next frame boundary.
- `cfg_base`  in  ADDR_WIDTH: first address of a frame.
- `cfg_len`  in  ADDR_WIDTH+1: words per frame, 1..2^ADDR_WIDTH.
- `cfg_loop`  in  1: 1 = repeat frames until stopped; 0 = single frame.
- `bram_en`  out  1: read enable.
- `bram_addr`  out  ADDR_WIDTH: read address.
- `bram_dout`  in  DATA_WIDTH: read data.
- `m_axis_tdata`  out  DATA_WIDTH: stream data.
- `m_axis_tvalid`  out  1: stream valid.
- `m_axis_tready`  in  1: stream ready.
- `m_axis_tlast`  out  1: marks the last word of each frame.
- `busy`  out  1: high from accepted start until the last word is transferred.
- `frame_done`  out  1: one-cycle pulse on each transfer with tlast.

## Operation
- States (shared enum): IDLE, RUN, DRAIN.
- **IDLE**
  - `start` is accepted only here, and only if `cfg_len` != 0.
  - On acceptance, `cfg_base`, `cfg_len` and `cfg_loop` are latched and the state goes to RUN.
  - `start` with `cfg_len` == 0 is ignored.
- **RUN**
  - One read is issued per cycle while credit is available.
  - Credit condition: outstanding reads + FIFO occupancy < FIFO_DEPTH (FIFO_DEPTH = READ_LATENCY+2).
  - The address increments modulo 2^ADDR_WIDTH, so a window may wrap past the top of the BRAM.
  - A per-read tag equal to (word index == len-1) travels in a READ_LATENCY-deep pipe alongside the read. It is written into the FIFO with the data and becomes `tlast`.
  - After the last word of a frame is issued:
    - if `cfg_loop` = 1 and no stop is pending, the address reloads `cfg_base` with no idle cycle;
    - otherwise the state goes to DRAIN.
- **stop**
  - `stop` in RUN sets a sticky pending flag; the frame in progress completes in full.
  - `stop` in IDLE or DRAIN is ignored.
- **DRAIN**
  - No new reads are issued.
  - The state returns to IDLE when the pipe and FIFO are empty; `busy` falls in that same cycle.
- **Backpressure**
  - Data is never dropped.
  - The credit rule guarantees FIFO space for every read in flight, so the BRAM is never stalled mid-read.
- **Stream rules**
  - `m_axis_tdata`/`m_axis_tlast` are held stable while `tvalid` is high and `tready` is low.
  - `tvalid` never deasserts without a transfer.
- **Config changes:** changes to the `cfg_*` inputs during a run have no effect until the next accepted `start`.
- **Reset:** asserting `rst` mid-run aborts immediately. The FIFO is flushed, the pipe is cleared and the state goes to IDLE; no partial frame is resumed.

## Timing
- Reset values: `bram_en`=0, `bram_addr`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `frame_done`=0.
- `start` sampled high at edge E:
  - `busy`=1, `bram_en`=1 and `bram_addr`=`cfg_base` in cycle E+1;
  - `bram_dout` valid in cycle E+1+READ_LATENCY;
  - first `tvalid` in cycle E+2+READ_LATENCY.
- With `tready` held high, throughput is 1 word/cycle sustained, including across loop frame boundaries.
- `tready` low for N cycles: reads stop within READ_LATENCY+1 cycles and resume at full rate one cycle after `tready` returns.
- `frame_done` is combinational: `tvalid & tready & tlast`.

## Structure
- Package `bram_stream_pkg` holds:
  - the state enum;
  - `fifo_depth(READ_LATENCY)` function;
  - the localparam for the tag width.
- Sub-module `stream_fifo`: synchronous FIFO, DEPTH = FIFO_DEPTH, width DATA_WIDTH+1, registered output, async active-low clear.
- Top level holds the FSM, address/word counters, credit counter and latency pipe.

## Test plan
- **One-shot:** base=0, len=32, loop=0, READ_LATENCY=2, `tready`=1 → 32 transfers carrying addresses 0..31; tlast on the 32nd only; first tvalid 4 cycles after start; `busy` low after the last transfer.
- **Wrap window:** base=30, len=4 → data from addresses 30, 31, 0, 1; tlast on address 1.
- **Loop and stop:** base=4, len=3, loop=1, stop pulsed mid-second-frame → exactly 2 full frames (6 words, tlast on words 3 and 6), no gap between frames, then IDLE.
- **Backpressure:** random 50% `tready` over len=32 → all 32 words in order, no duplicates or drops, and data/tlast stable while stalled; repeat for READ_LATENCY 1 and 3.
- **Illegal start:** `cfg_len`=0 start → `busy` stays 0 and no `bram_en`; a `start` while busy is ignored and the frame count is unchanged.
- **Async reset:** `rst` asserted mid-frame between clock edges → outputs reach reset values immediately; the next start replays from `cfg_base` with tlast placement correct.
